if_id_stage_reg: RTL and testbench

Parametrised successor to the basic IF/ID pipeline register, with a valid/ready handshake, a bubble-inserting flush and an optional skid buffer. Fetch uses it to hand the instruction word, the return address and the branch-select flag to decode. It lets decode stall without losing a fetched word and lets the branch unit squash in-flight instructions. With SKID=1 the block is a 2-entry elastic buffer. With SKID=0 it is a single stallable register.

---
 rtl/if_id_stage_reg.sv | 116 +++++++++++
 tb/tb_if_id_stage_reg.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/if_id_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_stage_reg
//  Description : IF/ID pipeline register with a valid/ready handshake,
//                a bubble-inserting flush and an optional 2-entry skid
//                buffer. It carries the instruction word, the return
//                address and the branch-select flag as one entry.
//  Revision    : 1.0  initial parametrised handshake version
// ============================================================================
module if_id_stage_reg #(
    parameter int                     INSTR_WIDTH = 32,
    parameter int                     ADDR_WIDTH  = 14,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = 32'h00000000,
    parameter int                     SKID        = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] instruction_in,
    input  logic [ADDR_WIDTH-1:0]  return_addr_in,
    input  logic                   take_branch_addr_in,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] instruction_out,
    output logic [ADDR_WIDTH-1:0]  return_addr_out,
    output logic                   take_branch_addr_out,
    output logic [1:0]             occupancy
);

    // One entry = {instruction, return address, branch-select flag}
    localparam int                     c_PAYLOAD_W = INSTR_WIDTH + ADDR_WIDTH + 1;
    localparam logic [c_PAYLOAD_W-1:0] c_BUBBLE    = {NOP_WORD, {ADDR_WIDTH{1'b0}}, 1'b0};

    logic [c_PAYLOAD_W-1:0] w_in_payload;
    logic                   w_accept;
    logic                   w_consume;
    logic                   w_s_valid;

    // Main (output) register: the outputs are driven straight from it, so
    // there is never a combinational path from the inputs to the payload.
    logic                   r_m_valid;
    logic [c_PAYLOAD_W-1:0] r_m_payload;

    assign w_in_payload = {instruction_in, return_addr_in, take_branch_addr_in};
    assign w_accept     = in_valid && in_ready;
    assign w_consume    = r_m_valid && out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic                   r_s_valid;
            logic [c_PAYLOAD_W-1:0] r_s_payload;

            // Ready depends on registered state only; the skid slot absorbs
            // the word that arrives while decode is stalling.
            assign in_ready  = !r_s_valid && !reset;
            assign w_s_valid = r_s_valid;

            // Two-entry FIFO update; an emptied slot reloads the bubble so a
            // stale word can never be presented to decode.
            always_ff @(posedge clock) begin
                if (reset || flush) begin
                    r_m_valid   <= 1'b0;
                    r_m_payload <= c_BUBBLE;
                    r_s_valid   <= 1'b0;
                    r_s_payload <= c_BUBBLE;
                end else if (r_s_valid) begin
                    // Full: no accept is possible, a consume promotes skid.
                    if (w_consume) begin
                        r_m_payload <= r_s_payload;
                        r_s_valid   <= 1'b0;
                        r_s_payload <= c_BUBBLE;
                    end
                end else if (r_m_valid) begin
                    if (w_accept && w_consume) begin
                        r_m_payload <= w_in_payload;
                    end else if (w_consume) begin
                        r_m_valid   <= 1'b0;
                        r_m_payload <= c_BUBBLE;
                    end else if (w_accept) begin
                        r_s_valid   <= 1'b1;
                        r_s_payload <= w_in_payload;
                    end
                end else if (w_accept) begin
                    r_m_valid   <= 1'b1;
                    r_m_payload <= w_in_payload;
                end
            end
        end else begin : g_single
            // Single entry: may refill in the same cycle decode drains it.
            assign in_ready  = (!r_m_valid || out_ready) && !reset;
            assign w_s_valid = 1'b0;

            // Stallable register; drains to the bubble when consumed.
            always_ff @(posedge clock) begin
                if (reset || flush) begin
                    r_m_valid   <= 1'b0;
                    r_m_payload <= c_BUBBLE;
                end else if (w_accept) begin
                    r_m_valid   <= 1'b1;
                    r_m_payload <= w_in_payload;
                end else if (w_consume) begin
                    r_m_valid   <= 1'b0;
                    r_m_payload <= c_BUBBLE;
                end
            end
        end
    endgenerate

    assign out_valid = r_m_valid;
    assign {instruction_out, return_addr_out, take_branch_addr_out} = r_m_payload;
    assign occupancy = {1'b0, r_m_valid} + {1'b0, w_s_valid};

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_stage_reg
//  Description : Self-checking bench for if_id_stage_reg. Drives a SKID=1
//                and a SKID=0 instance with the same inputs and compares
//                both against queue-based reference models.
//  Revision    : 1.0  initial bench
// ============================================================================
module tb_if_id_stage_reg;

    localparam logic [46:0] c_BUBBLE = 47'd0;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [31:0] instruction_in;
    logic [13:0] return_addr_in;
    logic        take_branch_addr_in;
    logic        flush;
    logic        out_ready;

    logic        in_ready1, out_valid1, take_branch_addr_out1;
    logic [31:0] instruction_out1;
    logic [13:0] return_addr_out1;
    logic [1:0]  occupancy1;

    logic        in_ready0, out_valid0, take_branch_addr_out0;
    logic [31:0] instruction_out0;
    logic [13:0] return_addr_out0;
    logic [1:0]  occupancy0;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        r_known  = 1'b0;
    logic [46:0] q1[$];
    logic [46:0] q0[$];

    if_id_stage_reg #(.SKID(1)) dut_skid (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .instruction_in(instruction_in), .return_addr_in(return_addr_in),
        .take_branch_addr_in(take_branch_addr_in), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready),
        .instruction_out(instruction_out1), .return_addr_out(return_addr_out1),
        .take_branch_addr_out(take_branch_addr_out1), .occupancy(occupancy1)
    );

    if_id_stage_reg #(.SKID(0)) dut_single (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .instruction_in(instruction_in), .return_addr_in(return_addr_in),
        .take_branch_addr_in(take_branch_addr_in), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready),
        .instruction_out(instruction_out0), .return_addr_out(return_addr_out0),
        .take_branch_addr_out(take_branch_addr_out0), .occupancy(occupancy0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare against the models, advance models.
    task automatic cycle(input logic rst, input logic iv, input logic [31:0] ins,
                         input logic [13:0] ra, input logic tbf, input logic fl,
                         input logic ordy);
        logic [46:0] ent, e1, e0;
        logic        rdy1, rdy0, acc1, acc0, con1, con0;
        reset               = rst;
        in_valid            = iv;
        instruction_in      = ins;
        return_addr_in      = ra;
        take_branch_addr_in = tbf;
        flush               = fl;
        out_ready           = ordy;
        ent  = {ins, ra, tbf};
        rdy1 = !rst && (q1.size() < 2);
        rdy0 = !rst && ((q0.size() == 0) || ordy);
        e1   = (q1.size() != 0) ? q1[0] : c_BUBBLE;
        e0   = (q0.size() != 0) ? q0[0] : c_BUBBLE;
        #3;
        if (r_known) begin
            check("skid_in_ready",  64'(in_ready1),  64'(rdy1));
            check("skid_out_valid", 64'(out_valid1), 64'(q1.size() != 0));
            check("skid_payload",   64'({instruction_out1, return_addr_out1, take_branch_addr_out1}), 64'(e1));
            check("skid_occupancy", 64'(occupancy1), 64'(q1.size()));
            check("single_in_ready",  64'(in_ready0),  64'(rdy0));
            check("single_out_valid", 64'(out_valid0), 64'(q0.size() != 0));
            check("single_payload",   64'({instruction_out0, return_addr_out0, take_branch_addr_out0}), 64'(e0));
            check("single_occupancy", 64'(occupancy0), 64'(q0.size()));
        end
        acc1 = iv && rdy1;
        acc0 = iv && rdy0;
        con1 = (q1.size() != 0) && ordy;
        con0 = (q0.size() != 0) && ordy;
        if (rst || fl) begin
            q1.delete();
            q0.delete();
        end else begin
            if (con1) void'(q1.pop_front());
            if (acc1) q1.push_back(ent);
            if (con0) void'(q0.pop_front());
            if (acc0) q0.push_back(ent);
        end
        if (rst) r_known = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] r_w;
        logic [31:0] r_a;
        reset = 1'b1; in_valid = 1'b0; instruction_in = '0; return_addr_in = '0;
        take_branch_addr_in = 1'b0; flush = 1'b0; out_ready = 1'b0;

        // Reset held two cycles with a word offered
        cycle(1, 1, 32'hDEADBEEF, 14'd5, 1, 0, 0);
        cycle(1, 1, 32'hDEADBEEF, 14'd5, 1, 0, 0);
        cycle(0, 0, 32'h0, 14'd0, 0, 0, 1);

        // Streaming
        cycle(0, 1, 32'h11, 14'd1, 0, 0, 1);
        cycle(0, 1, 32'h22, 14'd2, 1, 0, 1);
        cycle(0, 1, 32'h33, 14'd3, 0, 0, 1);
        cycle(0, 0, 32'h0,  14'd0, 0, 0, 1);
        cycle(0, 0, 32'h0,  14'd0, 0, 0, 1);

        // Stall then drain
        cycle(0, 1, 32'hA1, 14'd10, 0, 0, 0);
        cycle(0, 1, 32'hA2, 14'd11, 1, 0, 0);
        cycle(0, 0, 32'h0,  14'd0,  0, 0, 0);
        cycle(0, 0, 32'h0,  14'd0,  0, 0, 1);
        cycle(0, 0, 32'h0,  14'd0,  0, 0, 1);
        cycle(0, 0, 32'h0,  14'd0,  0, 0, 1);

        // Flush while full with a word offered
        cycle(0, 1, 32'hB1, 14'd20, 0, 0, 0);
        cycle(0, 1, 32'hB2, 14'd21, 0, 0, 0);
        cycle(0, 1, 32'hB3, 14'd22, 1, 1, 0);
        cycle(0, 0, 32'h0,  14'd0,  0, 0, 1);
        cycle(0, 0, 32'h0,  14'd0,  0, 0, 1);

        // Single-entry refill in the draining cycle
        cycle(0, 1, 32'hC4, 14'd30, 0, 0, 0);
        cycle(0, 0, 32'h0,  14'd0,  0, 0, 0);
        cycle(0, 1, 32'hC5, 14'd31, 1, 0, 1);
        cycle(0, 0, 32'h0,  14'd0,  0, 0, 0);
        cycle(0, 0, 32'h0,  14'd0,  0, 0, 1);
        cycle(0, 0, 32'h0,  14'd0,  0, 0, 1);

        // Reset mid-operation while full
        cycle(0, 1, 32'hD1, 14'd40, 0, 0, 0);
        cycle(0, 1, 32'hD2, 14'd41, 1, 0, 0);
        cycle(1, 1, 32'hD3, 14'd42, 0, 0, 0);
        cycle(0, 0, 32'h0,  14'd0,  0, 0, 1);
        cycle(0, 0, 32'h0,  14'd0,  0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r_w = $urandom;
            r_a = $urandom;
            cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), r_w, r_a[13:0],
                  r_a[20], ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) != 0));
        end
        cycle(0, 0, 32'h0, 14'd0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
